// File: rtl/soc_evt_async_src.sv
`default_nettype none
// ============================================================================
// Module   : soc_evt_async_src
// Brief    : SoC-side producer of a pointer-based CDC event queue. Round-robin
//            merges N_CH event channels into a 2**LOG_DEPTH entry buffer and
//            exports a gray write pointer plus the entry array.
//            Optional accepted-event counter: SOC_EVT_ASYNC_SRC_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module soc_evt_async_src #(
    parameter  int N_CH       = 4,
    parameter  int EVNT_WIDTH = 8,
    parameter  int LOG_DEPTH  = 3,
    localparam int CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                                              clk_i,
    input  logic                                              rst_i,
    input  logic [N_CH-1:0]                                   evt_valid_i,
    output logic [N_CH-1:0]                                   evt_ready_o,
    input  logic [N_CH-1:0][EVNT_WIDTH-1:0]                   evt_data_i,
    output logic [LOG_DEPTH:0]                                async_evt_wptr_o,
    output logic [2**LOG_DEPTH-1:0][CH_W+EVNT_WIDTH-1:0]      async_evt_data_o,
    input  logic [LOG_DEPTH:0]                                async_evt_rptr_i,
    output logic                                              full_o,
    output logic [LOG_DEPTH:0]                                level_o,
    output logic [15:0]                                       evt_count_o
);

    localparam int                 c_PTR_W   = LOG_DEPTH + 1;
    localparam int                 c_ENTRIES = 2**LOG_DEPTH;
    localparam int                 c_ENT_W   = CH_W + EVNT_WIDTH;
    localparam logic [LOG_DEPTH:0] c_DEPTH   = c_PTR_W'(c_ENTRIES);

    logic [LOG_DEPTH:0]                   r_wptr_bin;
    logic [LOG_DEPTH:0]                   r_wptr_gray;
    logic [LOG_DEPTH:0]                   w_wptr_bin_nxt;
    logic [LOG_DEPTH:0]                   w_rptr_bin;
    logic [LOG_DEPTH:0]                   w_level;
    logic [c_ENTRIES-1:0][c_ENT_W-1:0]    r_mem;
    logic [CH_W-1:0]                      r_rr;
    logic [CH_W-1:0]                      w_grant;
    logic [CH_W-1:0]                      w_cand;
    logic                                 w_grant_vld;
    logic                                 w_full;
    logic                                 w_push;

    // Each binary bit is the parity of all gray bits at or above it.
    always_comb begin
        w_rptr_bin = '0;
        for (int i = 0; i < c_PTR_W; i++) begin
            w_rptr_bin[i] = ^(async_evt_rptr_i >> i);
        end
    end

    assign w_level        = r_wptr_bin - w_rptr_bin;
    assign w_full         = (w_level == c_DEPTH);
    assign w_wptr_bin_nxt = r_wptr_bin + c_PTR_W'(1);

    // First requesting channel at or after the round-robin pointer.
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant     = '0;
        w_cand      = '0;
        for (int i = 0; i < N_CH; i++) begin
            w_cand = CH_W'((int'(r_rr) + i) % N_CH);
            if (!w_grant_vld && evt_valid_i[w_cand]) begin
                w_grant_vld = 1'b1;
                w_grant     = w_cand;
            end
        end
    end

    assign w_push = w_grant_vld & ~w_full & ~rst_i;

    always_comb begin
        evt_ready_o = '0;
        for (int i = 0; i < N_CH; i++) begin
            evt_ready_o[i] = w_push && (w_grant == CH_W'(i));
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wptr_bin  <= '0;
            r_wptr_gray <= '0;
            r_rr        <= '0;
            r_mem       <= '0;
        end else if (w_push) begin
            r_mem[r_wptr_bin[LOG_DEPTH-1:0]] <= {w_grant, evt_data_i[w_grant]};
            r_wptr_bin  <= w_wptr_bin_nxt;
            r_wptr_gray <= w_wptr_bin_nxt ^ (w_wptr_bin_nxt >> 1);
            r_rr        <= CH_W'((int'(w_grant) + 1) % N_CH);
        end
    end

`ifdef SOC_EVT_ASYNC_SRC_CNT_EN
    logic [15:0] r_evt_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_evt_cnt <= '0;
        end else if (w_push && (r_evt_cnt != 16'hFFFF)) begin
            r_evt_cnt <= r_evt_cnt + 16'd1;
        end
    end

    assign evt_count_o = r_evt_cnt;
`else
    assign evt_count_o = 16'h0000;
`endif

    assign async_evt_wptr_o = r_wptr_gray;
    assign async_evt_data_o = r_mem;
    assign full_o           = w_full;
    assign level_o          = w_level;

    // A legal consumer never frees more than is written nor steps backwards.
    a_level_bound : assert property (@(posedge clk_i) disable iff (rst_i)
        (w_level <= c_DEPTH));
    a_rptr_step : assert property (@(posedge clk_i) disable iff (rst_i)
        (c_PTR_W'(w_rptr_bin - $past(w_rptr_bin)) <= c_DEPTH));

endmodule
`default_nettype wire

// File: tb/tb_soc_evt_async_src.sv
`default_nettype none
// ============================================================================
// Module   : tb_soc_evt_async_src
// Brief    : Scoreboard bench for soc_evt_async_src (4 channels, depth 8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_soc_evt_async_src;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic [3:0]       evt_valid_i;
    logic [3:0]       evt_ready_o;
    logic [3:0][7:0]  evt_data_i;
    logic [3:0]       async_evt_wptr_o;
    logic [7:0][9:0]  async_evt_data_o;
    logic [3:0]       async_evt_rptr_i;
    logic             full_o;
    logic [3:0]       level_o;
    logic [15:0]      evt_count_o;

    soc_evt_async_src #(
        .N_CH       (4),
        .EVNT_WIDTH (8),
        .LOG_DEPTH  (3)
    ) u_dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .evt_valid_i      (evt_valid_i),
        .evt_ready_o      (evt_ready_o),
        .evt_data_i       (evt_data_i),
        .async_evt_wptr_o (async_evt_wptr_o),
        .async_evt_data_o (async_evt_data_o),
        .async_evt_rptr_i (async_evt_rptr_i),
        .full_o           (full_o),
        .level_o          (level_o),
        .evt_count_o      (evt_count_o)
    );

    always #5 clk_i = ~clk_i;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [9:0] sb[$];
    logic [3:0] wptr_m;
    logic [3:0] rptr_m;
    int         rr_m;
    int         cnt_m;

    function automatic logic [3:0] gray(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Predict grant/full/level at mid-cycle, then advance the model across the edge.
    task automatic cycle();
        logic [3:0] lvl;
        logic       full_e;
        logic [3:0] rdy_e;
        logic [1:0] c;
        logic [1:0] gi;
        int         g;
        @(negedge clk_i);
        lvl    = wptr_m - rptr_m;
        full_e = (lvl == 4'd8);
        g      = -1;
        gi     = 2'd0;
        for (int i = 0; i < 4; i++) begin
            c = 2'((rr_m + i) % 4);
            if (g < 0 && evt_valid_i[c]) begin
                g  = int'(c);
                gi = c;
            end
        end
        rdy_e = (g >= 0 && !full_e) ? 4'(1 << g) : 4'b0000;
        chk("ready", evt_ready_o, rdy_e);
        chk("full",  full_o, full_e);
        chk("level", level_o, lvl);
        chk("wptr",  async_evt_wptr_o, gray(wptr_m));
        if (rdy_e != 4'b0000) begin
            sb.push_back({gi, evt_data_i[gi]});
            wptr_m = wptr_m + 4'd1;
            rr_m   = (g + 1) % 4;
            cnt_m++;
        end
        @(posedge clk_i);
        #1;
    endtask

    // Consumer side: compare the oldest entry and free it.
    task automatic drain_one();
        if (sb.size() > 0) begin
            chk("sb_data", async_evt_data_o[rptr_m[2:0]], sb.pop_front());
            rptr_m           = rptr_m + 4'd1;
            async_evt_rptr_i = gray(rptr_m);
        end
    endtask

    task automatic do_reset(input logic [3:0] v_during);
        rst_i            = 1'b1;
        evt_valid_i      = v_during;
        async_evt_rptr_i = 4'd0;
        @(negedge clk_i);
        chk("rst_ready", evt_ready_o, 4'b0000);
        @(posedge clk_i);
        #1;
        chk("rst_wptr",  async_evt_wptr_o, 4'd0);
        chk("rst_level", level_o, 4'd0);
        rst_i       = 1'b0;
        evt_valid_i = 4'b0000;
        wptr_m      = 4'd0;
        rptr_m      = 4'd0;
        rr_m        = 0;
        cnt_m       = 0;
        sb.delete();
    endtask

    initial begin
        logic [3:0] prev;
        logic [1:0] ch;
        rst_i            = 1'b1;
        evt_valid_i      = 4'b0000;
        evt_data_i       = '0;
        async_evt_rptr_i = 4'd0;
        wptr_m = 4'd0; rptr_m = 4'd0; rr_m = 0; cnt_m = 0;

        // Reset state
        do_reset(4'hF);
        chk("rst_full", full_o, 1'b0);
        chk("rst_cnt",  evt_count_o, 16'd0);
        chk("idle_ready", evt_ready_o, 4'b0000);
        for (int i = 0; i < 8; i++) chk("rst_data", async_evt_data_o[i], 10'd0);

        // Single event on channel 2
        evt_data_i[2] = 8'hA5;
        evt_valid_i   = 4'b0100;
        cycle();
        evt_valid_i = 4'b0000;
        chk("ch2_wptr",  async_evt_wptr_o, 4'b0001);
        chk("ch2_level", level_o, 4'd1);
        chk("ch2_entry", async_evt_data_o[0], 10'h2A5);
        drain_one();

        // All channels requesting until full
        do_reset(4'h0);
        evt_valid_i = 4'hF;
        for (int k = 0; k < 8; k++) begin
            for (int c2 = 0; c2 < 4; c2++) evt_data_i[c2] = 8'(k * 16 + c2);
            cycle();
        end
        cycle();
        chk("full_flag", full_o, 1'b1);
        chk("full_wptr", async_evt_wptr_o, 4'b1100);
        chk("full_level", level_o, 4'd8);

        // Consumer frees one slot while full: push proceeds that cycle
        drain_one();
        evt_data_i[0] = 8'h5C;
        cycle();
        chk("refill_full", full_o, 1'b1);
        chk("refill_wptr", async_evt_wptr_o, 4'b1101);
        evt_valid_i = 4'b0000;
        repeat (9) begin
            drain_one();
            cycle();
        end

        // 40 single-channel pushes with a draining consumer
        do_reset(4'h0);
        for (int i = 0; i < 40; i++) begin
            ch             = 2'(i % 4);
            evt_data_i[ch] = 8'(i * 7 + 3);
            evt_valid_i    = 4'(1 << ch);
            prev           = async_evt_wptr_o;
            cycle();
            chk("gray_step", 64'($countones(prev ^ async_evt_wptr_o)), 64'd1);
            drain_one();
        end
        evt_valid_i = 4'b0000;
        chk("wrap_wptr", async_evt_wptr_o, gray(4'd8));
`ifdef SOC_EVT_ASYNC_SRC_CNT_EN
        chk("cnt40", evt_count_o, 16'd40);
`else
        chk("cnt40", evt_count_o, 16'd0);
`endif

        // Reset in the middle of a burst
        do_reset(4'h0);
        evt_valid_i = 4'hF;
        repeat (5) cycle();
        chk("mid_level", level_o, 4'd5);
        do_reset(4'hF);
        evt_valid_i = 4'hF;
        evt_data_i  = {8'h44, 8'h33, 8'h22, 8'h11};
        cycle();
        chk("rr_restart", async_evt_data_o[0], 10'h011);
        evt_valid_i = 4'b0000;
        drain_one();
        cycle();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
